mem_wb_pipe_reg: RTL
====================

Name: mem_wb_pipe_reg

Overview:
- Parametrised MEM→WB pipeline register for the five-stage MIPS core. Sits between the data-memory stage and register-file writeback.
- Unlike the earlier pass-through stage, it is a true clocked register. It supports stall (hold), flush (bubble insertion), valid tracking, exception/branch-delay carry, a self-decrementing Tnew for the hazard unit, and a pre-resolved writeback register/data pair.

Parameters:
- DATA_W, 32, width of PC, ALU result, memory read data and writeback data
- REG_AW, 5, register-file address width
- TNEW_W, 4, width of the Tnew hazard counter
- EXC_W, 5, exception-code width (0 = no exception)
- RESET_PC, 32'h0000_3000, PC value held after reset and in reset bubbles

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold current contents this cycle
- flush  input  1  replace contents with bubble this cycle
- instr_i  input  32  instruction from MEM
- pc_i  input  DATA_W  PC of instruction in MEM
- alu_i  input  DATA_W  ALU result from MEM
- dmem_i  input  DATA_W  data-memory read data from MEM
- regwrite_i  input  1  instruction writes register file
- dst_i  input  REG_AW  destination register (already rt/rd/31 resolved)
- wbsel_i  input  2  writeback source: 0 ALU, 1 memory, 2 PC+8, 3 reserved
- tnew_i  input  TNEW_W  Tnew as seen in MEM
- exc_i  input  EXC_W  exception code accumulated so far
- bd_i  input  1  instruction is in a branch-delay slot
- valid_o  output  1  register holds a real instruction
- instr_o  output  32  registered instruction
- pc_o  output  DATA_W  registered PC
- pc8_o  output  DATA_W  pc_o + 8, combinational from pc_o
- exc_o  output  EXC_W  registered exception code
- bd_o  output  1  registered delay-slot flag
- tnew_o  output  TNEW_W  current Tnew of the WB instruction
- wreg_o  output  REG_AW  effective write register (0 when no write)
- wdata_o  output  DATA_W  selected writeback data
- we_o  output  1  register-file write enable
- retire_o  output  1  one-cycle pulse per instruction leaving WB

Behaviour:
- Reset (async, any time, including mid-stall):
  - valid_o=0, instr_o=0, pc_o=RESET_PC, exc_o=0, bd_o=0, tnew_o=0.
  - Internal alu, dmem, regwrite, dst and wbsel state cleared, so we_o=0, wreg_o=0, wdata_o=0, retire_o=0.
- Update priority per rising edge: reset > flush > stall > load.
- Load:
  - All fields captured from *_i; valid_o=1.
  - tnew_o = tnew_i-1, saturating at 0.
- Stall:
  - All fields hold, except tnew_o, which decrements by 1 saturating at 0.
  - retire_o=0 during stall.
- Flush:
  - instr_o=0, valid_o=0, regwrite cleared, exc_o=0, tnew_o=0.
  - pc_o and bd_o still load pc_i/bd_i so EPC tracking stays correct.
  - Flush with stall asserted together: flush wins.
- Writeback resolution (combinational from registered state):
  - we_o = valid_o & regwrite & (exc_o==0) & (dst!=0).
  - wreg_o = we_o ? dst : 0.
  - wdata_o selects alu, dmem or pc8_o per wbsel; wbsel=3 yields 0.
  - wdata_o = 0 whenever we_o=0.
- pc8_o: addition wraps modulo 2^DATA_W.
- retire_o: registered; asserted for exactly one cycle on the edge after a valid, exception-free instruction was held in WB and the stage was not stalled.
- Latency: one cycle from MEM inputs to WB outputs; zero-cycle combinational path only from registered state to we_o/wreg_o/wdata_o/pc8_o.

Test Plan:
- Reset mid-operation: assert reset while valid_o=1, wreg_o=8 → same cycle valid_o=0, pc_o=32'h3000, we_o=0, wreg_o=0.
- Normal load: instr_i=lw, dst_i=9, wbsel_i=1, dmem_i=32'hDEAD_BEEF, tnew_i=2 → next cycle we_o=1, wreg_o=9, wdata_o=32'hDEAD_BEEF, tnew_o=1.
- Stall hold: load jal at pc_i=32'h3010 with wbsel_i=2, dst_i=31, then stall 3 cycles → wdata_o=32'h3018 throughout, tnew_o stays at 0 (saturation), no retire_o pulse until stall drops.
- Flush priority: flush=1 and stall=1 with pc_i=32'h3020, bd_i=1 → valid_o=0, we_o=0, tnew_o=0, pc_o=32'h3020, bd_o=1.
- Exception suppression: load addu with dst_i=5, exc_i=4 → we_o=0, wreg_o=0, exc_o=4, retire_o never pulses.
- Zero register: load with dst_i=0, regwrite_i=1, alu_i=7 → we_o=0, wreg_o=0, wdata_o=0.

Source files
------------

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: stall/flush control, Tnew countdown, retire pulse
// and writeback port resolution from the registered state.
module mem_wb_pipe_reg #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          REG_AW   = 5,
  parameter int unsigned          TNEW_W   = 4,
  parameter int unsigned          EXC_W    = 5,
  parameter logic [DATA_W-1:0]    RESET_PC = DATA_W'(32'h0000_3000)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic [31:0]         instr_i,
  input  logic [DATA_W-1:0]   pc_i,
  input  logic [DATA_W-1:0]   alu_i,
  input  logic [DATA_W-1:0]   dmem_i,
  input  logic                regwrite_i,
  input  logic [REG_AW-1:0]   dst_i,
  input  logic [1:0]          wbsel_i,
  input  logic [TNEW_W-1:0]   tnew_i,
  input  logic [EXC_W-1:0]    exc_i,
  input  logic                bd_i,
  output logic                valid_o,
  output logic [31:0]         instr_o,
  output logic [DATA_W-1:0]   pc_o,
  output logic [DATA_W-1:0]   pc8_o,
  output logic [EXC_W-1:0]    exc_o,
  output logic                bd_o,
  output logic [TNEW_W-1:0]   tnew_o,
  output logic [REG_AW-1:0]   wreg_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic                we_o,
  output logic                retire_o
);

  localparam int unsigned INSTR_W = 32;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC8  = 2'd2;

  logic                valid_q,    valid_d;
  logic [INSTR_W-1:0]  instr_q,    instr_d;
  logic [DATA_W-1:0]   pc_q,       pc_d;
  logic [DATA_W-1:0]   alu_q,      alu_d;
  logic [DATA_W-1:0]   dmem_q,     dmem_d;
  logic                regwrite_q, regwrite_d;
  logic [REG_AW-1:0]   dst_q,      dst_d;
  logic [1:0]          wbsel_q,    wbsel_d;
  logic [TNEW_W-1:0]   tnew_q,     tnew_d;
  logic [EXC_W-1:0]    exc_q,      exc_d;
  logic                bd_q,       bd_d;
  logic                retire_q,   retire_d;

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    tnew_dec = (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  // Next-state selection: flush beats stall beats load.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    alu_d      = alu_q;
    dmem_d     = dmem_q;
    regwrite_d = regwrite_q;
    dst_d      = dst_q;
    wbsel_d    = wbsel_q;
    tnew_d     = tnew_q;
    exc_d      = exc_q;
    bd_d       = bd_q;
    // The WB occupant leaves unless the stage is genuinely held.
    retire_d   = valid_q & (exc_q == '0) & ~(stall & ~flush);

    if (flush) begin
      valid_d    = 1'b0;
      instr_d    = '0;
      regwrite_d = 1'b0;
      exc_d      = '0;
      tnew_d     = '0;
      pc_d       = pc_i;
      bd_d       = bd_i;
      alu_d      = alu_i;
      dmem_d     = dmem_i;
      dst_d      = dst_i;
      wbsel_d    = wbsel_i;
    end else if (stall) begin
      tnew_d     = tnew_dec(tnew_q);
    end else begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_d       = pc_i;
      alu_d      = alu_i;
      dmem_d     = dmem_i;
      regwrite_d = regwrite_i;
      dst_d      = dst_i;
      wbsel_d    = wbsel_i;
      tnew_d     = tnew_dec(tnew_i);
      exc_d      = exc_i;
      bd_d       = bd_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= RESET_PC;
      alu_q      <= '0;
      dmem_q     <= '0;
      regwrite_q <= 1'b0;
      dst_q      <= '0;
      wbsel_q    <= '0;
      tnew_q     <= '0;
      exc_q      <= '0;
      bd_q       <= 1'b0;
      retire_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      alu_q      <= alu_d;
      dmem_q     <= dmem_d;
      regwrite_q <= regwrite_d;
      dst_q      <= dst_d;
      wbsel_q    <= wbsel_d;
      tnew_q     <= tnew_d;
      exc_q      <= exc_d;
      bd_q       <= bd_d;
      retire_q   <= retire_d;
    end
  end

  // Writeback resolution: a non-writing instruction presents all-zero port values.
  always_comb begin
    pc8_o   = pc_q + DATA_W'(8);
    we_o    = valid_q & regwrite_q & (exc_q == '0) & (dst_q != '0);
    wreg_o  = '0;
    wdata_o = '0;
    if (we_o) begin
      wreg_o = dst_q;
      case (wbsel_q)
        WB_ALU:  wdata_o = alu_q;
        WB_MEM:  wdata_o = dmem_q;
        WB_PC8:  wdata_o = pc8_o;
        default: wdata_o = '0;
      endcase
    end
  end

  assign valid_o  = valid_q;
  assign instr_o  = instr_q;
  assign pc_o     = pc_q;
  assign exc_o    = exc_q;
  assign bd_o     = bd_q;
  assign tnew_o   = tnew_q;
  assign retire_o = retire_q;

endmodule
